// File: rtl/types_def.sv
// Shared widths and request types for the memory request path.
package types_def;

    localparam int unsigned data_width       = 32;
    localparam int unsigned read_entries_log = 3;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } r_type;

endpackage

// File: rtl/returner_ack_fifo.sv
// Show-ahead FIFO for write-completion tags; pointers carry an extra wrap bit.
module returner_ack_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data_c,
    output logic             empty_c,
    output logic             full_c,
    output logic             drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty_c     = (wptr == rptr);
    assign full_c      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop      = pop && !empty_c;
    // A push into a full FIFO still lands when a pop frees the slot this cycle.
    assign do_push     = push && (!full_c || do_pop);
    assign drop_c      = push && !do_push;
    assign head_data_c = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/returner.sv
// Reorders read completions back into tag order and queues write acknowledges.
module returner
    import types_def::*;
#(
    parameter int unsigned WR_ACK_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        returner_valid,
    input  r_type                       returner_type,
    input  logic [data_width-1:0]       returner_data,
    input  logic [read_entries_log-1:0] returner_index,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [data_width-1:0]       rd_data,
    output logic [read_entries_log-1:0] rd_index,
    output logic                        wr_ack_valid,
    input  logic                        wr_ack_ready,
    output logic [read_entries_log-1:0] wr_ack_index,
    output logic [read_entries_log-1:0] rd_head,
    output logic                        err_dup,
    output logic                        err_wr_ovf
);

    localparam int unsigned RD_ENTRIES = 2 ** read_entries_log;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t                  state_q;
    out_state_t                  state_d;
    logic [data_width-1:0]       tbl_data [RD_ENTRIES];
    logic [RD_ENTRIES-1:0]       tbl_valid;
    logic [read_entries_log-1:0] head;
    logic                        rd_arrive_c;
    logic                        wr_arrive_c;
    logic                        head_hit_c;
    logic                        load_c;
    logic                        ack_empty_c;
    logic                        ack_full_c;
    logic                        ack_drop_c;

    assign rd_arrive_c = returner_valid && (returner_type == read);
    assign wr_arrive_c = returner_valid && (returner_type == write);
    // Uses the valid bit before this cycle's arrival: no same-cycle bypass.
    assign head_hit_c  = tbl_valid[head];

    // Output stage state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Output stage next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (head_hit_c) state_d = FULL;
            FULL:    if (rd_ready && !head_hit_c) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output stage load decode
    always_comb begin
        load_c = 1'b0;
        case (state_q)
            EMPTY:   load_c = head_hit_c;
            FULL:    load_c = head_hit_c && rd_ready;
            default: load_c = 1'b0;
        endcase
    end

    assign rd_valid = (state_q == FULL);
    assign rd_head  = head;

    // Payload, head pointer, slot valid bits and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data    <= '0;
            rd_index   <= '0;
            head       <= '0;
            tbl_valid  <= '0;
            err_dup    <= 1'b0;
            err_wr_ovf <= 1'b0;
        end else begin
            if (load_c) begin
                rd_data         <= tbl_data[head];
                rd_index        <= head;
                head            <= head + read_entries_log'(1);
                tbl_valid[head] <= 1'b0;
            end
            // An arrival overrides a same-cycle clear so the new data is not lost.
            if (rd_arrive_c) begin
                tbl_valid[returner_index] <= 1'b1;
                if (tbl_valid[returner_index]) err_dup <= 1'b1;
            end
            if (ack_drop_c) err_wr_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_arrive_c) tbl_data[returner_index] <= returner_data;
    end

    returner_ack_fifo #(
        .WIDTH (read_entries_log),
        .DEPTH (WR_ACK_DEPTH)
    ) u_ack_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (wr_arrive_c),
        .push_data   (returner_index),
        .pop         (wr_ack_valid && wr_ack_ready),
        .head_data_c (wr_ack_index),
        .empty_c     (ack_empty_c),
        .full_c      (ack_full_c),
        .drop_c      (ack_drop_c)
    );

    assign wr_ack_valid = !ack_empty_c;

endmodule
